dcache_controller: RTL and testbench

//  Direct-mapped, write-back, write-allocate L1 data cache controller between MEM stage and data memory.

---
 rtl/dcache_controller.sv | 153 +++++++++++++++
 tb/tb_dcache_controller.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_controller.sv
// dcache_controller: direct-mapped, write-back, write-allocate L1 data cache between the MEM stage and a line-wide memory.
// Latency: hits return load data combinationally; a miss stalls for an optional writeback plus a refill and one settle cycle.
// Backpressure: cpu_stall_o freezes the pipeline on any miss; memory traffic is paced by mem_enable_o/mem_ack_i.
module dcache_controller #(
  parameter int ADDR_W    = 32,
  parameter int WORD_W    = 32,
  parameter int LINE_W    = 256,
  parameter int NUM_LINES = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [WORD_W-1:0] cpu_data_i,
  input  logic              cpu_MemRead_i,
  input  logic              cpu_MemWrite_i,
  output logic [WORD_W-1:0] cpu_data_o,
  output logic              cpu_stall_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i
);

  localparam int OFF_W  = $clog2(LINE_W / 8);
  localparam int WSEL_W = $clog2(LINE_W / WORD_W);
  localparam int BSEL_W = OFF_W - WSEL_W;
  localparam int BIT_W  = $clog2(LINE_W);
  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;

  typedef enum logic [2:0] {
    IDLE,
    MISS,
    WRITEBACK,
    REFILL,
    REFILL_DONE
  } state_t;

  state_t state;

  logic [NUM_LINES-1:0] valid;
  logic [NUM_LINES-1:0] dirty;
  logic [TAG_W-1:0]     tag_arr  [NUM_LINES];
  logic [LINE_W-1:0]    data_arr [NUM_LINES];

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic [WSEL_W-1:0] wsel;
  logic [BIT_W-1:0]  wbit;
  logic              req;
  logic              is_store;
  logic              hit;
  logic              read_hit;
  logic              write_hit;
  logic              refill_ack;
  logic              unused_byte_sel;

  assign idx  = cpu_addr_i[OFF_W +: IDX_W];
  assign tag  = cpu_addr_i[ADDR_W-1 -: TAG_W];
  assign wsel = cpu_addr_i[BSEL_W +: WSEL_W];
  assign wbit = {wsel, {(BIT_W - WSEL_W){1'b0}}};

  // Byte lanes inside a word are not used: accesses are whole words.
  assign unused_byte_sel = ^cpu_addr_i[BSEL_W-1:0];

  // Read+write together behaves as a store.
  assign req       = cpu_MemRead_i | cpu_MemWrite_i;
  assign is_store  = cpu_MemWrite_i;
  assign hit       = req & valid[idx] & (tag_arr[idx] == tag);
  assign read_hit  = hit & ~is_store;
  // Stores only commit from IDLE, so the word merge after a refill happens once the request re-hits.
  assign write_hit = hit & is_store & (state == IDLE);
  // Only the ack of a refill request actually on the bus loads the line.
  assign refill_ack = (state == REFILL) & mem_enable_o & mem_ack_i;

  assign cpu_stall_o = (req & ~hit) | (state != IDLE);
  assign cpu_data_o  = read_hit ? data_arr[idx][wbit +: WORD_W] : '0;

  // Line data and tag storage: refill writes a whole line, a store hit merges one word.
  always_ff @(posedge clk_i) begin
    if (!rst_i && refill_ack) begin
      data_arr[idx] <= mem_data_i;
      tag_arr[idx]  <= tag;
    end else if (!rst_i && write_hit) begin
      data_arr[idx][wbit +: WORD_W] <= cpu_data_i;
    end
  end

  // Miss FSM with registered memory-side outputs plus valid/dirty bookkeeping.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      valid        <= '0;
      dirty        <= '0;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (write_hit) begin
            dirty[idx] <= 1'b1;
          end else if (req && !hit) begin
            state <= MISS;
          end
        end
        MISS: begin
          mem_enable_o <= 1'b1;
          if (valid[idx] && dirty[idx]) begin
            state       <= WRITEBACK;
            mem_write_o <= 1'b1;
            mem_addr_o  <= {tag_arr[idx], idx, {OFF_W{1'b0}}};
            mem_data_o  <= data_arr[idx];
          end else begin
            state       <= REFILL;
            mem_write_o <= 1'b0;
            mem_addr_o  <= {tag, idx, {OFF_W{1'b0}}};
          end
        end
        WRITEBACK: begin
          // Drop the request for one cycle so memory sees the fill as a fresh transaction.
          if (mem_ack_i) begin
            state        <= REFILL;
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
          end
        end
        REFILL: begin
          if (!mem_enable_o) begin
            mem_enable_o <= 1'b1;
            mem_write_o  <= 1'b0;
            mem_addr_o   <= {tag, idx, {OFF_W{1'b0}}};
          end else if (mem_ack_i) begin
            state        <= REFILL_DONE;
            mem_enable_o <= 1'b0;
            valid[idx]   <= 1'b1;
            dirty[idx]   <= 1'b0;
          end
        end
        REFILL_DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_controller.sv
// tb_dcache_controller: directed load/store sequences against a transaction-level cache and memory model.
// Latency: memory responder acks each request a fixed number of cycles after it is raised.
// Backpressure: every access waits on cpu_stall_o with a bounded cycle budget.
module tb_dcache_controller;

  localparam int ACK_DLY = 5;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  cpu_addr = '0;
  logic [31:0]  cpu_wdata = '0;
  logic         cpu_rd = 1'b0;
  logic         cpu_wr = 1'b0;
  logic [31:0]  cpu_rdata;
  logic         stall;
  logic         mem_en;
  logic         mem_wr;
  logic [31:0]  mem_addr;
  logic [255:0] mem_wdata;
  logic [255:0] mem_rdata = '0;
  logic         mem_ack = 1'b0;

  int checks = 0;
  int errors = 0;

  bit          chk_en = 1'b0;
  bit          resp_en = 1'b1;
  bit          req_active = 1'b0;
  logic [31:0] exp_rdata = '0;
  logic [31:0] last_rdata = '0;

  typedef struct packed {
    logic         wr;
    logic [31:0]  addr;
    logic [255:0] data;
  } txn_t;

  txn_t         log_q[$];
  logic [255:0] mem_model [logic [31:0]];

  bit           cm_valid [16];
  bit           cm_dirty [16];
  logic [22:0]  cm_tag   [16];
  logic [255:0] cm_line  [16];

  dcache_controller dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .cpu_addr_i     (cpu_addr),
    .cpu_data_i     (cpu_wdata),
    .cpu_MemRead_i  (cpu_rd),
    .cpu_MemWrite_i (cpu_wr),
    .cpu_data_o     (cpu_rdata),
    .cpu_stall_o    (stall),
    .mem_enable_o   (mem_en),
    .mem_write_o    (mem_wr),
    .mem_addr_o     (mem_addr),
    .mem_data_o     (mem_wdata),
    .mem_data_i     (mem_rdata),
    .mem_ack_i      (mem_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Backing memory: lines appear with a deterministic pattern on first touch.
  function automatic logic [255:0] get_line(input logic [31:0] a);
    logic [255:0] l;
    if (!mem_model.exists(a)) begin
      for (int i = 0; i < 8; i++) begin
        l[i*32 +: 32] = a ^ (32'h0101_0101 * i) ^ 32'h5A5A_0000;
      end
      mem_model[a] = l;
    end
    return mem_model[a];
  endfunction

  // Memory responder: logs each request, checks it stays stable, acks after ACK_DLY cycles.
  initial begin
    int   wait_cnt;
    txn_t snap;
    wait_cnt = 0;
    snap = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!resp_en) begin
        wait_cnt = 0;
      end else begin
        mem_ack = 1'b0;
        if (rst || !mem_en) begin
          wait_cnt = 0;
        end else begin
          if (wait_cnt == 0) begin
            snap.wr   = mem_wr;
            snap.addr = mem_addr;
            snap.data = mem_wdata;
          end else begin
            chk("mem_wr_stable", mem_wr, snap.wr);
            chk("mem_addr_stable", mem_addr, snap.addr);
            if (snap.wr) chk("mem_data_stable", mem_wdata, snap.data);
          end
          wait_cnt++;
          if (wait_cnt == ACK_DLY) begin
            mem_ack  = 1'b1;
            wait_cnt = 0;
            log_q.push_back(snap);
            if (snap.wr) mem_model[snap.addr] = snap.data;
            else         mem_rdata = get_line(snap.addr);
          end
        end
      end
    end
  end

  // Per-cycle compare against the model while the bench owns the interface.
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      if (req_active) begin
        if (!stall) begin
          chk("cpu_data", cpu_rdata, exp_rdata);
          chk("mem_en_unstalled", mem_en, 1'b0);
        end
      end else begin
        chk("idle_stall", stall, 1'b0);
        chk("idle_data", cpu_rdata, 32'h0);
        chk("idle_mem_en", mem_en, 1'b0);
      end
    end
  end

  task automatic model_clear();
    for (int i = 0; i < 16; i++) begin
      cm_valid[i] = 1'b0;
      cm_dirty[i] = 1'b0;
      cm_tag[i]   = '0;
      cm_line[i]  = '0;
    end
  endtask

  // One CPU access: predict from the model, drive, wait out the stall, compare memory traffic.
  task automatic access(input string nm, input logic [31:0] a, input logic [31:0] d,
                        input logic rd, input logic wr);
    int          idx;
    int          w;
    int          n;
    logic [22:0] tg;
    bit          hit;
    txn_t        e;
    txn_t        exp_q[$];
    idx = int'(a[8:5]);
    w   = int'(a[4:2]);
    tg  = a[31:9];
    hit = cm_valid[idx] && (cm_tag[idx] == tg);
    if (!hit) begin
      if (cm_valid[idx] && cm_dirty[idx]) begin
        e.wr   = 1'b1;
        e.addr = {cm_tag[idx], a[8:5], 5'b0};
        e.data = cm_line[idx];
        exp_q.push_back(e);
      end
      e.wr   = 1'b0;
      e.addr = {a[31:5], 5'b0};
      e.data = '0;
      exp_q.push_back(e);
      cm_line[idx]  = get_line(e.addr);
      cm_valid[idx] = 1'b1;
      cm_dirty[idx] = 1'b0;
      cm_tag[idx]   = tg;
    end
    if (wr) begin
      cm_line[idx][w*32 +: 32] = d;
      cm_dirty[idx] = 1'b1;
    end
    exp_rdata = (rd && !wr) ? cm_line[idx][w*32 +: 32] : 32'h0;
    log_q.delete();

    cpu_addr   = a;
    cpu_wdata  = d;
    cpu_rd     = rd;
    cpu_wr     = wr;
    req_active = 1'b1;
    @(negedge clk);
    chk({nm, " first_stall"}, stall, !hit);
    n = 0;
    while (stall && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (stall) chk({nm, " stall_timeout"}, stall, 1'b0);
    last_rdata = cpu_rdata;
    @(posedge clk);
    #1;
    cpu_rd     = 1'b0;
    cpu_wr     = 1'b0;
    req_active = 1'b0;

    chk({nm, " txn_count"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      chk({nm, " txn_wr"}, log_q[i].wr, exp_q[i].wr);
      chk({nm, " txn_addr"}, log_q[i].addr, exp_q[i].addr);
      if (exp_q[i].wr) chk({nm, " txn_data"}, log_q[i].data, exp_q[i].data);
    end
  endtask

  initial begin
    logic [255:0] l;
    int           n;
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [255:0] l;
    int           n;
    model_clear();
    l = get_line(32'h40);
    l[95:64] = 32'hDEAD_BEEF;
    mem_model[32'h40] = l;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_stall", stall, 1'b0);
    chk("rst_mem_en", mem_en, 1'b0);
    chk("rst_mem_wr", mem_wr, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_cpu_data", cpu_rdata, 32'h0);
    rst = 1'b0;
    chk_en = 1'b1;

    access("cold_ld_40", 32'h40, 32'h0, 1'b1, 1'b0);
    chk("cold_ntxn", log_q.size(), 1);
    if (log_q.size() >= 1) chk("cold_fill", {log_q[0].wr, log_q[0].addr}, {1'b0, 32'h40});

    access("ld_48", 32'h48, 32'h0, 1'b1, 1'b0);
    chk("ld_48_value", last_rdata, 32'hDEAD_BEEF);

    access("ld_hit_44", 32'h44, 32'h0, 1'b1, 1'b0);
    chk("hit_ntxn", log_q.size(), 0);

    access("st_40", 32'h40, 32'h1111_2222, 1'b0, 1'b1);
    access("ld_240", 32'h240, 32'h0, 1'b1, 1'b0);
    chk("evict_ntxn", log_q.size(), 2);
    if (log_q.size() >= 2) begin
      chk("evict_wb", {log_q[0].wr, log_q[0].addr}, {1'b1, 32'h40});
      chk("evict_wb_word0", log_q[0].data[31:0], 32'h1111_2222);
      chk("evict_fill", {log_q[1].wr, log_q[1].addr}, {1'b0, 32'h240});
    end

    access("ld_40_clean", 32'h40, 32'h0, 1'b1, 1'b0);
    chk("clean_ntxn", log_q.size(), 1);
    if (log_q.size() >= 1) chk("clean_fill", {log_q[0].wr, log_q[0].addr}, {1'b0, 32'h40});

    access("st_miss_8c", 32'h8C, 32'hCAFE_F00D, 1'b0, 1'b1);
    chk("st_miss_ntxn", log_q.size(), 1);
    access("ld_8c", 32'h8C, 32'h0, 1'b1, 1'b0);
    chk("ld_8c_value", last_rdata, 32'hCAFE_F00D);
    access("ld_480", 32'h480, 32'h0, 1'b1, 1'b0);
    if (log_q.size() >= 1) begin
      chk("merge_wb", {log_q[0].wr, log_q[0].addr}, {1'b1, 32'h80});
      chk("merge_wb_word3", log_q[0].data[127:96], 32'hCAFE_F00D);
    end

    access("st_1fc", 32'h1FC, 32'h7777_0001, 1'b0, 1'b1);
    access("ld_44_wrap", 32'h44, 32'h0, 1'b1, 1'b0);
    chk("wrap_ntxn", log_q.size(), 0);
    access("ld_1fc", 32'h1FC, 32'h0, 1'b1, 1'b0);
    chk("ld_1fc_value", last_rdata, 32'h7777_0001);

    access("rdwr_44", 32'h44, 32'hABCD_0123, 1'b1, 1'b1);
    access("ld_44_after", 32'h44, 32'h0, 1'b1, 1'b0);
    chk("rdwr_value", last_rdata, 32'hABCD_0123);

    // Reset in the middle of a refill, then a stray ack.
    resp_en    = 1'b0;
    chk_en     = 1'b0;
    cpu_addr   = 32'h300;
    cpu_rd     = 1'b1;
    req_active = 1'b1;
    n = 0;
    while (!(mem_en && !mem_wr) && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("abort_refill_seen", {mem_en, mem_wr}, 2'b10);
    chk("abort_refill_addr", mem_addr, 32'h300);
    rst        = 1'b1;
    cpu_rd     = 1'b0;
    req_active = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_mem_en", mem_en, 1'b0);
    chk("abort_stall", stall, 1'b0);
    @(posedge clk);
    #1;
    mem_ack = 1'b1;
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    @(negedge clk);
    chk("late_ack_mem_en", mem_en, 1'b0);
    chk("late_ack_stall", stall, 1'b0);
    @(posedge clk);
    #1;
    resp_en = 1'b1;
    chk_en  = 1'b1;
    model_clear();

    access("post_rst_48", 32'h48, 32'h0, 1'b1, 1'b0);
    chk("post_rst_ntxn", log_q.size(), 1);
    if (log_q.size() >= 1) chk("post_rst_fill", {log_q[0].wr, log_q[0].addr}, {1'b0, 32'h40});
    chk("post_rst_value", last_rdata, 32'hDEAD_BEEF);
    access("post_rst_300", 32'h300, 32'h0, 1'b1, 1'b0);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
